// File: rtl/value_selector.sv
// rtl/value_selector.sv - debounced button to bounded up/down value selector
// Optional hold-to-repeat stepping is compiled in with VALUE_SELECTOR_AUTOREPEAT_EN.
module value_selector #(
  parameter int WIDTH           = 3,
  parameter int MAX_VAL         = 5,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             dir,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             at_limit
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic          btn_s1, btn_s2, dir_s1, dir_s2;
  logic [DW-1:0] db_cnt;
  logic          db, db_q;
  logic          rise, req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      dir_s1 <= dir;
      dir_s2 <= dir_s1;
    end
  end

  // The counter only advances while the synced level disagrees with db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db     <= 1'b0;
      db_q   <= 1'b0;
    end else begin
      db_q <= db;
      if (btn_s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        db     <= btn_s2;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign rise = db & ~db_q;

`ifdef VALUE_SELECTOR_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_target;
  logic          repeating;
  logic          rep_req;

  // hold_cnt is the number of cycles since the last step request of this hold.
  assign hold_target = repeating ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY);
  assign rep_req     = db & db_q & (hold_cnt == hold_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (!db) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (rise) begin
      hold_cnt  <= HW'(1);
      repeating <= 1'b0;
    end else if (rep_req) begin
      hold_cnt  <= HW'(1);
      repeating <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign req = rise | rep_req;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign req = rise;
`endif

  logic [WIDTH-1:0] value_nxt;
  logic             step_nxt, limit_nxt;

  // Limits are tested before the +/-1 so the arithmetic never overflows WIDTH.
  always_comb begin
    value_nxt = value;
    step_nxt  = 1'b0;
    limit_nxt = 1'b0;
    if (value > MAX) begin
      value_nxt = '0;
    end else if (req) begin
      step_nxt = 1'b1;
      if (dir_s2) begin
        if (value < MAX) begin
          value_nxt = value + WIDTH'(1);
        end else begin
          limit_nxt = 1'b1;
          if (WRAP != 0) value_nxt = '0;
        end
      end else begin
        if (value > '0) begin
          value_nxt = value - WIDTH'(1);
        end else begin
          limit_nxt = 1'b1;
          if (WRAP != 0) value_nxt = MAX;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= '0;
      step     <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      value    <= value_nxt;
      step     <= step_nxt;
      at_limit <= limit_nxt;
    end
  end

endmodule

// File: doc/value_selector.md
# value_selector

Clocked, parametrised successor to the front-panel count selector: converts a raw push-button and a direction switch into a bounded operand count. The block synchronises and debounces the button, then steps a WIDTH-bit value up or down on each debounced press. The value stays in 0..MAX_VAL, either wrapping or saturating at the limits. It sits between the board I/O pins and the operation core that consumes `value`.

## Interface
- `WIDTH`, 3: width of `value`.
- `MAX_VAL`, 5: highest legal value; must be ≤ 2^WIDTH−1 and ≥ 1.
- `WRAP`, 1: 1 = wrap at limits, 0 = saturate.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required to accept a level change; ≥ 1.
- `REPEAT_DELAY`, 500: hold cycles before the first auto-repeat step; used only with auto-repeat compiled in.
- `REPEAT_PERIOD`, 100: cycles between subsequent auto-repeat steps; used only with auto-repeat compiled in.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn`, input, 1: raw, asynchronous, bouncy button.
- `dir`, input, 1: 1 = increment, 0 = decrement; sampled through the same 2-flop synchroniser as `btn`.
- `value`, output, WIDTH: current selection.
- `step`, output, 1: one-cycle pulse in the cycle `value` changes or would have changed.
- `at_limit`, output, 1: one-cycle pulse, coincident with `step`, when the step hit a limit (wrapped or saturated).

## Operation
- Synchroniser: 2 flops each for `btn` and `dir`.
- Debouncer:
  - Counter compares synced `btn` with the debounced level `db`.
  - On mismatch the counter increments; on match it clears.
  - When it reaches DEBOUNCE_CYCLES, `db` takes the synced value and the counter clears.
- Edge detect: a rising edge of `db` produces an internal step request. A falling edge produces nothing.
- Step request, `dir`=1:
  - `value` < MAX_VAL: `value`+1.
  - `value` = MAX_VAL and WRAP=1: `value` becomes 0, `at_limit`=1.
  - `value` = MAX_VAL and WRAP=0: `value` unchanged, `at_limit`=1.
- Step request, `dir`=0:
  - `value` > 0: `value`−1.
  - `value` = 0 and WRAP=1: `value` becomes MAX_VAL, `at_limit`=1.
  - `value` = 0 and WRAP=0: `value` unchanged, `at_limit`=1.
- `dir` is taken from its synced value in the cycle the request is acted on. A `dir` change while the button is held affects only later steps.
- Out-of-range guard: if `value` > MAX_VAL in any cycle, it is forced to 0 on the next edge, with no `step` pulse. This state is unreachable in normal operation.
- Arithmetic: WIDTH bits, comparisons unsigned, no intermediate overflow, because the limits are checked before ±1.

## Timing
- Reset (`rst_n`=0, asynchronous): `value`=0, `step`=0, `at_limit`=0, `db`=0, debounce counter=0, sync flops=0, repeat counter=0.
- Release of `rst_n` is synchronous to `clk`; the first edge after deassertion may update state.
- Press latency: from the first edge sampling a stable `btn`=1 to `value` update = 2 (sync) + DEBOUNCE_CYCLES + 1 edges. `step` is high in the same cycle `value` shows the new value.
- Glitches shorter than DEBOUNCE_CYCLES cycles cause no step.
- Reset asserted mid-debounce or mid-hold: everything clears. A button still held at release must first debounce high before it can step.
- Maximum step rate: one step per debounced press (or per repeat period). Never two steps in consecutive cycles.

## Configuration
- `VALUE_SELECTOR_AUTOREPEAT_EN` defined:
  - While `db` stays 1, a hold counter runs.
  - At REPEAT_DELAY cycles after the initial step, a further step is issued, then one every REPEAT_PERIOD cycles.
  - The counter clears when `db` falls or on reset.
  - Wrap/saturate rules and `at_limit` apply to each repeat step.
- Not defined: the hold counter is absent and a held button yields exactly one step.

## Test plan
- Reset then 6 clean presses, `dir`=1, MAX_VAL=5, WRAP=1 → `value` 1,2,3,4,5,0; `at_limit` pulses only on 5→0.
- `value`=0, press with `dir`=0: WRAP=1 → `value`=5 with `at_limit`; WRAP=0 → stays 0 with `at_limit` and `step`.
- Bounce: pulses of 3 cycles on `btn` with DEBOUNCE_CYCLES=16 → no `step`. A stable press → exactly one `step`, at 2+16+1 edges.
- `rst_n` pulled low while `value`=3 and the button is mid-debounce → `value`=0 immediately (asynchronous). No `step` until a fresh stable press after release.
- With the macro, REPEAT_DELAY=50, REPEAT_PERIOD=10, hold for 100 debounced cycles, `dir`=1 from 0 → steps at hold offsets 0, 50, 60, 70, 80, 90; `value` 1,2,3,4,5,0. Without the macro → a single step, `value`=1.
- `dir` toggled while the button is held (macro on) → the next repeat step follows the new direction; no extra step is generated.
